// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a producer/consumer pair and fifo_sync_param.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             r_en;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             full_flag;
  logic             empty_flag;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // FIFO side
  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, valid, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );

  // producer/consumer side
  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, valid, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO: full DEPTH usage, occupancy count, almost thresholds,
// sticky overflow/underflow, standard or first-word-fall-through read.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    w_ptr, r_ptr;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic             wr_acc, rd_acc;

  // explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // accept decisions use only registered flags; next occupancy feeds the flag registers
  always_comb begin
    wr_acc  = bus.w_en && !full_q;
    rd_acc  = bus.r_en && !empty_q;
    cnt_nxt = cnt;
    if (wr_acc && !rd_acc)      cnt_nxt = cnt + 1'b1;
    else if (rd_acc && !wr_acc) cnt_nxt = cnt - 1'b1;
  end

  // storage: not reset, and writes are blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[w_ptr] <= bus.data_in;
  end

  // pointers, occupancy, registered flags and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= ptr_inc(w_ptr);
      if (rd_acc) r_ptr <= ptr_inc(r_ptr);
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == DEPTH_C);
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= AF_C);
      ae_q    <= (cnt_nxt <= AE_C);
      // a set in the same cycle as clr_err wins
      ovf_q   <= (bus.w_en && full_q)  || (ovf_q && !bus.clr_err);
      unf_q   <= (bus.r_en && empty_q) || (unf_q && !bus.clr_err);
    end
  end

  if (FWFT) begin : g_fwft
    // head word is visible whenever the FIFO is non-empty; zero while empty
    assign bus.data_out = empty_q ? '0 : mem[r_ptr];
    assign bus.valid    = !empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data;
    logic             rd_vld;
    // registered read: data held between reads, valid pulses one cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data <= '0;
        rd_vld  <= 1'b0;
      end else begin
        rd_vld <= rd_acc;
        if (rd_acc) rd_data <= mem[r_ptr];
      end
    end
    assign bus.data_out = rd_data;
    assign bus.valid    = rd_vld;
  end

  assign bus.count        = cnt;
  assign bus.full_flag    = full_q;
  assign bus.empty_flag   = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench: standard and FWFT instances driven in lockstep and compared
// against a queue-based model of the FIFO rules.
module tb_fifo_sync_param;
  localparam int W = 8;
  localparam int D = 8;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic gclk = 1'b0;
  logic rst = 1'b0, w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
  logic [W-1:0] data_in = '0;
  int n_cmp = 0, n_err = 0;

  always #5 gclk = ~gclk;

  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  assign if0.w_en = w_en;  assign if0.data_in = data_in;
  assign if0.r_en = r_en;  assign if0.clr_err = clr_err;
  assign if1.w_en = w_en;  assign if1.data_in = data_in;
  assign if1.r_en = r_en;  assign if1.clr_err = clr_err;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) u_std  (.clk(gclk), .rst(rst), .bus(if0));
  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) u_fwft (.clk(gclk), .rst(rst), .bus(if1));

  // reference state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  bit m_vld = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rs, input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bit was_full, was_empty;
    if (rs) begin
      q.delete();
      m_dout = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    m_vld = 0;
    if (r && !was_empty) begin
      m_dout = q.pop_front();
      m_vld  = 1;
    end
    if (w && !was_full) q.push_back(d);
    m_ovf = (w && was_full)  || (m_ovf && !c);
    m_unf = (r && was_empty) || (m_unf && !c);
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count",    if0.count, sz);
    chk("full",     if0.full_flag, sz == D);
    chk("empty",    if0.empty_flag, sz == 0);
    chk("afull",    if0.almost_full, sz >= AF);
    chk("aempty",   if0.almost_empty, sz <= AE);
    chk("overflow", if0.overflow, m_ovf);
    chk("underflow",if0.underflow, m_unf);
    chk("std_valid",if0.valid, m_vld);
    chk("std_dout", if0.data_out, m_dout);
    chk("fw_count", if1.count, sz);
    chk("fw_ovf",   if1.overflow, m_ovf);
    chk("fw_unf",   if1.underflow, m_unf);
    chk("fw_valid", if1.valid, sz != 0);
    if (sz != 0) chk("fw_dout", if1.data_out, q[0]);
  endtask

  // one clock: drive, edge, model, sample 1ns after edge
  task automatic step(input bit rs, input bit w, input logic [W-1:0] d, input bit r, input bit c);
    rst = rs; w_en = w; data_in = d; r_en = r; clr_err = c;
    @(posedge gclk);
    model_edge(rs, w, d, r, c);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] pat;
    int wp, rp;
    // reset with a concurrent write
    step(1, 1, 8'h55, 0, 0);
    chk("rst_dout", if0.data_out, 0);
    // fill, then one rejected write
    for (int i = 1; i <= D; i++) step(0, 1, W'(i), 0, 0);
    step(0, 1, 8'hFF, 0, 0);
    chk("ovf_set", if0.overflow, 1);
    // drain plus one extra read
    for (int i = 0; i < D + 1; i++) step(0, 0, '0, 1, 0);
    chk("dout_hold", if0.data_out, 8'h08);
    // preload 3, then simultaneous read/write across the wrap
    step(0, 0, '0, 0, 1);
    pat = 8'h10;
    for (int i = 0; i < 3; i++) begin step(0, 1, pat, 0, 0); pat++; end
    for (int i = 0; i < 10; i++) begin step(0, 1, pat, 1, 0); pat++; end
    chk("steady_cnt", if0.count, 3);
    // FWFT fall-through and pop
    step(1, 0, '0, 0, 0);
    step(0, 1, 8'hA5, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("fw_a5", if1.data_out, 8'hA5);
    step(0, 0, '0, 1, 0);
    chk("fw_pop", if1.valid, 0);
    // reset at count 5 with write
    for (int i = 0; i < 5; i++) step(0, 1, W'(8'h30 + i), 0, 0);
    step(1, 1, 8'h77, 0, 0);
    chk("rst_cnt", if0.count, 0);
    // error set / clear / set-wins
    for (int i = 0; i < D; i++) step(0, 1, W'(8'h40 + i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);
    step(0, 0, '0, 0, 1);
    chk("ovf_clr", if0.overflow, 0);
    step(0, 1, 8'hEE, 0, 1);
    chk("ovf_win", if0.overflow, 1);
    // full with both requests: read wins, write rejected
    step(0, 1, 8'hEF, 1, 0);
    chk("full_rw", if0.count, D - 1);
    // empty with both requests: write wins, read rejected
    step(1, 0, '0, 0, 0);
    step(0, 1, 8'h9C, 1, 0);
    chk("empty_rw", if0.underflow, 1);
    // random traffic with biased phases
    wp = 50; rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wp = $urandom_range(15, 85);
        rp = $urandom_range(15, 85);
      end
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < wp,
           W'($urandom),
           $urandom_range(0, 99) < rp,
           $urandom_range(0, 19) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
